// File: rtl/flopoco_pkg.sv
// Shared FloPoCo definitions: exception codes, IEEE class enum and word-width helpers.
package flopoco_pkg;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } fp_class_e;

  function automatic int ieee_w(input int we, input int wf);
    return we + wf + 1;
  endfunction

  function automatic int fp_w(input int we, input int wf);
    return we + wf + 3;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 class decode from exponent and fraction fields.
module fp_classify
  import flopoco_pkg::*;
#(
  parameter int WE = 11,
  parameter int WF = 52
) (
  input  logic [WE-1:0] exp,
  input  logic [WF-1:0] frac,
  output fp_class_e     cls
);

  logic exp_zero, exp_ones, frac_zero;

  assign exp_zero  = (exp == '0);
  assign exp_ones  = (exp == '1);
  assign frac_zero = (frac == '0);

  always_comb begin
    cls = CLS_NORM;
    if (exp_zero)      cls = frac_zero ? CLS_ZERO : CLS_SUB;
    else if (exp_ones) cls = frac_zero ? CLS_INF  : CLS_NAN;
  end

endmodule

// File: rtl/ieee_to_flopoco_pipe.sv
// Two-stage valid/ready encoder from IEEE binary64 to FloPoCo {exn, sign, exp, frac},
// flushing subnormals to zero and counting the flushes seen at the output.
module ieee_to_flopoco_pipe
  import flopoco_pkg::*;
#(
  parameter int WE    = 11,
  parameter int WF    = 52,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ieee_w(WE,WF)-1:0]      in_ieee,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [fp_w(WE,WF)-1:0]        out_fp,
  output logic                          out_flushed,
  output logic [CNT_W-1:0]              flush_count
);

  localparam int IW = ieee_w(WE, WF);
  localparam int FW = fp_w(WE, WF);

  // vld_pipe[1] = stage 1 full, vld_pipe[2] = stage 2 (output) full
  logic [2:1]      vld_pipe;
  logic            stage1_adv, stage2_adv;
  logic [IW-1:0]   s1_word;
  logic            s1_sign;
  fp_class_e       s1_cls, in_cls;
  logic [FW-1:0]   fp_pack;

  assign stage2_adv = !vld_pipe[2] || out_ready;
  assign stage1_adv = !vld_pipe[1] || stage2_adv;
  assign in_ready   = stage1_adv;
  assign out_valid  = vld_pipe[2];

  fp_classify #(.WE(WE), .WF(WF)) u_cls (
    .exp  (in_ieee[IW-2 -: WE]),
    .frac (in_ieee[WF-1:0]),
    .cls  (in_cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      if (stage1_adv) vld_pipe[1] <= in_valid;
      if (stage2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_word <= '0;
      s1_sign <= 1'b0;
      s1_cls  <= CLS_ZERO;
    end else if (stage1_adv && in_valid) begin
      s1_word <= in_ieee;
      s1_sign <= in_ieee[IW-1];
      s1_cls  <= in_cls;
    end
  end

  // NaN drops both payload and sign; every non-normal class zeroes exp/frac
  always_comb begin
    fp_pack = '0;
    unique case (s1_cls)
      CLS_NORM: fp_pack = {EXN_NORM, s1_sign, s1_word[IW-2:0]};
      CLS_ZERO,
      CLS_SUB:  fp_pack = {EXN_ZERO, s1_sign, {(WE+WF){1'b0}}};
      CLS_INF:  fp_pack = {EXN_INF,  s1_sign, {(WE+WF){1'b0}}};
      CLS_NAN:  fp_pack = {EXN_NAN,  1'b0,    {(WE+WF){1'b0}}};
      default:  fp_pack = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_fp      <= '0;
      out_flushed <= 1'b0;
    end else if (stage2_adv && vld_pipe[1]) begin
      out_fp      <= fp_pack;
      out_flushed <= (s1_cls == CLS_SUB);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_count <= '0;
    end else if (out_valid && out_ready && out_flushed && (flush_count != '1)) begin
      flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
